// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - shared constants, row type and FSM states for the grid writer
package grid_pkg;
  localparam int GRID_W = 10;
  localparam int GRID_H = 20;
  localparam int X_W = 4;
  localparam int Y_W = 5;

  // Coordinate-width limits so range checks compare like-sized operands
  localparam logic [X_W-1:0] X_LIM = X_W'(GRID_W);
  localparam logic [Y_W-1:0] Y_LIM = Y_W'(GRID_H);
  localparam logic [Y_W-1:0] Y_TOP = Y_W'(GRID_H - 1);

  typedef logic [GRID_W-1:0] row_t;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    SCAN,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/grid_lock_writer_if.sv
// rtl/grid_lock_writer_if.sv - lock request handshake and completion status bundle
interface grid_lock_writer_if;
  logic                         lock_valid;
  logic                         lock_ready;
  logic [4*grid_pkg::X_W-1:0]   cell_x;
  logic [4*grid_pkg::Y_W-1:0]   cell_y;
  logic                         lock_done;
  logic [2:0]                   lines_cleared;
  logic                         lock_overlap;

  modport master (
    output lock_valid, cell_x, cell_y,
    input  lock_ready, lock_done, lines_cleared, lock_overlap
  );

  modport slave (
    input  lock_valid, cell_x, cell_y,
    output lock_ready, lock_done, lines_cleared, lock_overlap
  );
endinterface

// File: rtl/grid_row_store.sv
// rtl/grid_row_store.sv - GRID_H row registers with set, row-copy, zero-row-0 and read ports
module grid_row_store
  import grid_pkg::*;
(
  input  logic           clock,
  input  logic           reset,
  input  logic           clr,
  input  logic           set_en,
  input  logic [X_W-1:0] set_x,
  input  logic [Y_W-1:0] set_y,
  output logic           set_old,
  input  logic           copy_en,
  input  logic [Y_W-1:0] copy_idx,
  input  logic           zero_en,
  input  logic [Y_W-1:0] full_idx,
  output logic           full,
  input  logic [X_W-1:0] rd_x,
  input  logic [Y_W-1:0] rd_y,
  output logic           rd_bit
);

  row_t rows [GRID_H];
  logic set_in;

  assign set_in = (set_x < X_LIM) && (set_y < Y_LIM);

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      for (int i = 0; i < GRID_H; i++) begin
        rows[i] <= '0;
      end
    end else begin
      if (copy_en && (copy_idx != '0) && (copy_idx < Y_LIM)) begin
        rows[copy_idx] <= rows[copy_idx - 1'b1];
      end
      if (zero_en) begin
        rows[0] <= '0;
      end
      if (set_en && set_in) begin
        rows[set_y][set_x] <= 1'b1;
      end
    end
  end

  // Out-of-range reads report solid so walls and floor need no special casing upstream
  always_comb begin
    set_old = 1'b0;
    full    = 1'b0;
    rd_bit  = 1'b1;
    if (set_in) begin
      set_old = rows[set_y][set_x];
    end
    if (full_idx < Y_LIM) begin
      full = &rows[full_idx];
    end
    if ((rd_x < X_LIM) && (rd_y < Y_LIM)) begin
      rd_bit = rows[rd_y][rd_x];
    end
  end

endmodule

// File: rtl/grid_lock_writer.sv
// rtl/grid_lock_writer.sv - stamps locked tetromino cells, clears full rows, shifts grid down
// Optional lifetime cleared-row counter on lines_total enabled by GRID_LINE_TOTAL_EN.
module grid_lock_writer
  import grid_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  grid_lock_writer_if.slave   lk,
  input  logic                clear_all,
  input  logic [X_W-1:0]      rd_x,
  input  logic [Y_W-1:0]      rd_y,
  output logic                rd_occupied,
  output logic [15:0]         lines_total
);

  state_t             state;
  state_t             state_nx;
  logic [4*X_W-1:0]   cx_q;
  logic [4*Y_W-1:0]   cy_q;
  logic [1:0]         k_q;
  logic [Y_W-1:0]     r_q;
  logic [Y_W-1:0]     s_q;
  logic [2:0]         clr_cnt_q;
  logic               ovl_q;
  logic               done_q;
  logic [2:0]         lc_q;
  logic               lo_q;

  logic               accept;
  logic               set_en;
  logic [X_W-1:0]     set_x;
  logic [Y_W-1:0]     set_y;
  logic               set_old;
  logic               copy_en;
  logic               zero_en;
  logic               full;

  assign accept           = lk.lock_valid && lk.lock_ready;
  assign lk.lock_ready    = (state == IDLE);
  assign lk.lock_done     = done_q;
  assign lk.lines_cleared = lc_q;
  assign lk.lock_overlap  = lo_q;

  grid_row_store u_store (
    .clock    (clock),
    .reset    (reset),
    .clr      (clear_all),
    .set_en   (set_en),
    .set_x    (set_x),
    .set_y    (set_y),
    .set_old  (set_old),
    .copy_en  (copy_en),
    .copy_idx (s_q),
    .zero_en  (zero_en),
    .full_idx (r_q),
    .full     (full),
    .rd_x     (rd_x),
    .rd_y     (rd_y),
    .rd_bit   (rd_occupied)
  );

  always_ff @(posedge clock) begin
    if (reset || clear_all) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    set_en   = 1'b0;
    copy_en  = 1'b0;
    zero_en  = 1'b0;
    set_x    = cx_q[X_W*k_q +: X_W];
    set_y    = cy_q[Y_W*k_q +: Y_W];
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = WRITE;
        end
      end
      WRITE: begin
        set_en = 1'b1;
        if (k_q == 2'd3) begin
          state_nx = SCAN;
        end
      end
      SCAN: begin
        if (full) begin
          state_nx = SHIFT;
        end else if (r_q == '0) begin
          state_nx = DONE;
        end
      end
      SHIFT: begin
        // Rescan the same row after the shift: the row that dropped in may be full too
        if (s_q != '0) begin
          copy_en = 1'b1;
        end else begin
          zero_en  = 1'b1;
          state_nx = SCAN;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || clear_all) begin
      cx_q      <= '0;
      cy_q      <= '0;
      k_q       <= '0;
      r_q       <= '0;
      s_q       <= '0;
      clr_cnt_q <= '0;
      ovl_q     <= 1'b0;
      done_q    <= 1'b0;
      lc_q      <= '0;
      lo_q      <= 1'b0;
    end else begin
      done_q <= (state == DONE);
      lc_q   <= (state == DONE) ? clr_cnt_q : 3'd0;
      lo_q   <= (state == DONE) && ovl_q;
      case (state)
        IDLE: begin
          if (accept) begin
            cx_q      <= lk.cell_x;
            cy_q      <= lk.cell_y;
            k_q       <= '0;
            clr_cnt_q <= '0;
            ovl_q     <= 1'b0;
          end
        end
        WRITE: begin
          k_q <= k_q + 1'b1;
          r_q <= Y_TOP;
          if (set_old) begin
            ovl_q <= 1'b1;
          end
        end
        SCAN: begin
          if (full) begin
            s_q <= r_q;
          end else if (r_q != '0) begin
            r_q <= r_q - 1'b1;
          end
        end
        SHIFT: begin
          if (s_q != '0) begin
            s_q <= s_q - 1'b1;
          end else if (clr_cnt_q != 3'd4) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef GRID_LINE_TOTAL_EN
  logic [15:0] total_q;
  logic        shift_ret;

  assign shift_ret   = (state == SHIFT) && (s_q == '0);
  assign lines_total = total_q;

  // Survives clear_all so it counts across games until a hard reset
  always_ff @(posedge clock) begin
    if (reset) begin
      total_q <= '0;
    end else if (!clear_all && shift_ret && (total_q != 16'hFFFF)) begin
      total_q <= total_q + 16'd1;
    end
  end
`else
  assign lines_total = '0;
`endif

endmodule

// File: tb/tb_grid_lock_writer.sv
// tb/tb_grid_lock_writer.sv - directed self-checking bench for grid_lock_writer
module tb_grid_lock_writer;
  logic        clock;
  logic        reset;
  logic        clear_all;
  logic [3:0]  rd_x;
  logic [4:0]  rd_y;
  logic        rd_occupied;
  logic [15:0] lines_total;

  grid_lock_writer_if lk ();

  grid_lock_writer dut (
    .clock       (clock),
    .reset       (reset),
    .lk          (lk),
    .clear_all   (clear_all),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .rd_occupied (rd_occupied),
    .lines_total (lines_total)
  );

`ifdef GRID_LINE_TOTAL_EN
  localparam bit TOTAL_EN = 1'b1;
`else
  localparam bit TOTAL_EN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  bit exp_g [20][10];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] px(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic logic [19:0] py(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic clear_exp();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        exp_g[y][x] = 1'b0;
  endtask

  task automatic grid_diff(output int bad, output int fx, output int fy);
    bad = 0; fx = 0; fy = 0;
    for (int y = 0; y < 20; y++) begin
      for (int x = 0; x < 10; x++) begin
        rd_x = 4'(x);
        rd_y = 5'(y);
        #1;
        if (rd_occupied !== exp_g[y][x]) begin
          if (bad == 0) begin fx = x; fy = y; end
          bad++;
        end
      end
    end
  endtask

  task automatic do_lock(input logic [15:0] xs, input logic [19:0] ys,
                         output int lat, output logic [2:0] lc, output logic ovl);
    int guard;
    guard = 0;
    @(negedge clock);
    lk.cell_x = xs;
    lk.cell_y = ys;
    lk.lock_valid = 1'b1;
    while (lk.lock_ready !== 1'b1 && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    @(posedge clock);
    #1;
    lk.lock_valid = 1'b0;
    lk.cell_x = ~xs;
    lk.cell_y = ~ys;
    lat = -1; lc = 3'b111; ovl = 1'b0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock);
      #1;
      if (lk.lock_done === 1'b1) begin
        lat = i; lc = lk.lines_cleared; ovl = lk.lock_overlap;
        break;
      end
    end
  endtask

  task automatic pulse_clear();
    @(negedge clock);
    clear_all = 1'b1;
    @(posedge clock);
    #1;
    clear_all = 1'b0;
  endtask

  task automatic test_reset();
    int bad, fx, fy;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++; if (lk.lock_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %0b want 1", lk.lock_ready); end
    n_cmp++; if (lk.lock_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0b want 0", lk.lock_done); end
    n_cmp++; if (lk.lines_cleared !== 3'd0) begin n_bad++; $display("FAIL reset_lines: got %0d want 0", lk.lines_cleared); end
    n_cmp++; if (lk.lock_overlap !== 1'b0) begin n_bad++; $display("FAIL reset_overlap: got %0b want 0", lk.lock_overlap); end
    n_cmp++; if (lines_total !== 16'd0) begin n_bad++; $display("FAIL reset_total: got %0d want 0", lines_total); end
    clear_exp();
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL reset_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
    rd_x = 4'd10; rd_y = 5'd0; #1;
    n_cmp++; if (rd_occupied !== 1'b1) begin n_bad++; $display("FAIL wall_x10: got %0b want 1", rd_occupied); end
    rd_x = 4'd0; rd_y = 5'd20; #1;
    n_cmp++; if (rd_occupied !== 1'b1) begin n_bad++; $display("FAIL floor_y20: got %0b want 1", rd_occupied); end
    rd_x = 4'd15; rd_y = 5'd31; #1;
    n_cmp++; if (rd_occupied !== 1'b1) begin n_bad++; $display("FAIL corner_oob: got %0b want 1", rd_occupied); end
  endtask

  task automatic test_single_lock();
    int lat, bad, fx, fy;
    logic [2:0] lc;
    logic ovl;
    do_lock(px(0, 1, 2, 3), py(19, 19, 19, 19), lat, lc, ovl);
    n_cmp++; if (lat != 25) begin n_bad++; $display("FAIL single_latency: got %0d want 25", lat); end
    n_cmp++; if (lc !== 3'd0) begin n_bad++; $display("FAIL single_lines: got %0d want 0", lc); end
    n_cmp++; if (ovl !== 1'b0) begin n_bad++; $display("FAIL single_overlap: got %0b want 0", ovl); end
    @(posedge clock);
    #1;
    n_cmp++; if (lk.lock_done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %0b want 0", lk.lock_done); end
    for (int x = 0; x < 4; x++) exp_g[19][x] = 1'b1;
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL single_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
  endtask

  task automatic test_one_line();
    int lat, bad, fx, fy;
    logic [2:0] lc;
    logic ovl;
    do_lock(px(4, 5, 0, 15), py(19, 19, 18, 0), lat, lc, ovl);
    n_cmp++; if (lat != 25 || lc !== 3'd0) begin n_bad++; $display("FAIL prefill: latency %0d lines %0d want 25 and 0", lat, lc); end
    do_lock(px(6, 7, 8, 9), py(19, 19, 19, 19), lat, lc, ovl);
    n_cmp++; if (lat != 46) begin n_bad++; $display("FAIL one_line_latency: got %0d want 46", lat); end
    n_cmp++; if (lc !== 3'd1) begin n_bad++; $display("FAIL one_line_lines: got %0d want 1", lc); end
    n_cmp++; if (ovl !== 1'b0) begin n_bad++; $display("FAIL one_line_overlap: got %0b want 0", ovl); end
    clear_exp();
    exp_g[19][0] = 1'b1;
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL one_line_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
    n_cmp++; if (lines_total !== (TOTAL_EN ? 16'd1 : 16'd0)) begin n_bad++; $display("FAIL one_line_total: got %0d", lines_total); end
  endtask

  task automatic test_four_lines();
    int lat, bad, fx, fy, slow;
    logic [2:0] lc;
    logic ovl;
    pulse_clear();
    clear_exp();
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0 || lk.lock_ready !== 1'b1) begin n_bad++; $display("FAIL idle_clear: %0d cells wrong, ready %0b", bad, lk.lock_ready); end
    slow = 0;
    for (int c = 0; c < 9; c++) begin
      do_lock(px(c, c, c, c), py(16, 17, 18, 19), lat, lc, ovl);
      if (lat != 25 || lc !== 3'd0) slow++;
    end
    n_cmp++; if (slow != 0) begin n_bad++; $display("FAIL column_fill: %0d of 9 locks had latency/lines off", slow); end
    do_lock(px(9, 9, 9, 9), py(16, 17, 18, 19), lat, lc, ovl);
    n_cmp++; if (lat != 109) begin n_bad++; $display("FAIL four_latency: got %0d want 109", lat); end
    n_cmp++; if (lc !== 3'd4) begin n_bad++; $display("FAIL four_lines: got %0d want 4", lc); end
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL four_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
    n_cmp++; if (lines_total !== (TOTAL_EN ? 16'd5 : 16'd0)) begin n_bad++; $display("FAIL four_total: got %0d", lines_total); end
  endtask

  task automatic test_overlap();
    int lat, bad, fx, fy;
    logic [2:0] lc;
    logic ovl;
    do_lock(px(4, 5, 6, 7), py(0, 0, 0, 0), lat, lc, ovl);
    n_cmp++; if (ovl !== 1'b0) begin n_bad++; $display("FAIL overlap_first: got %0b want 0", ovl); end
    do_lock(px(4, 4, 3, 3), py(0, 1, 0, 1), lat, lc, ovl);
    n_cmp++; if (ovl !== 1'b1 || lc !== 3'd0 || lat != 25) begin n_bad++; $display("FAIL overlap_hit: ovl %0b lines %0d lat %0d want 1 0 25", ovl, lc, lat); end
    for (int x = 3; x < 8; x++) exp_g[0][x] = 1'b1;
    exp_g[1][3] = 1'b1;
    exp_g[1][4] = 1'b1;
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL overlap_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
  endtask

  task automatic test_clear_during_shift();
    int lat, bad, fx, fy, seen;
    logic [2:0] lc;
    logic ovl;
    pulse_clear();
    clear_exp();
    do_lock(px(0, 1, 2, 3), py(19, 19, 19, 19), lat, lc, ovl);
    do_lock(px(4, 5, 6, 7), py(19, 19, 19, 19), lat, lc, ovl);
    @(negedge clock);
    lk.cell_x = px(8, 9, 0, 1);
    lk.cell_y = py(19, 19, 18, 18);
    lk.lock_valid = 1'b1;
    @(posedge clock);
    #1;
    lk.lock_valid = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    n_cmp++; if (lk.lock_ready !== 1'b0) begin n_bad++; $display("FAIL shift_busy: ready %0b want 0", lk.lock_ready); end
    clear_all = 1'b1;
    @(posedge clock);
    #1;
    clear_all = 1'b0;
    n_cmp++; if (lk.lock_ready !== 1'b1) begin n_bad++; $display("FAIL abort_ready: got %0b want 1", lk.lock_ready); end
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      if (lk.lock_done === 1'b1) seen++;
      @(posedge clock);
      #1;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL abort_no_done: %0d done cycles want 0", seen); end
    grid_diff(bad, fx, fy);
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL abort_grid: %0d cells wrong, first (%0d,%0d) want %0b", bad, fx, fy, exp_g[fy][fx]); end
    n_cmp++; if (lines_total !== (TOTAL_EN ? 16'd5 : 16'd0)) begin n_bad++; $display("FAIL abort_total: got %0d", lines_total); end
  endtask

  task automatic test_back_to_back();
    int busy_bad, lat;
    @(negedge clock);
    lk.cell_x = px(0, 1, 2, 3);
    lk.cell_y = py(5, 5, 5, 5);
    lk.lock_valid = 1'b1;
    @(posedge clock);
    busy_bad = 0;
    for (int i = 1; i < 25; i++) begin
      @(posedge clock);
      #1;
      if (lk.lock_ready !== 1'b0 || lk.lock_done !== 1'b0) busy_bad++;
    end
    n_cmp++; if (busy_bad != 0) begin n_bad++; $display("FAIL held_ignored: %0d busy cycles showed ready or done", busy_bad); end
    @(posedge clock);
    #1;
    n_cmp++; if (lk.lock_done !== 1'b1 || lk.lock_ready !== 1'b1 || lk.lock_overlap !== 1'b0) begin
      n_bad++; $display("FAIL held_first_done: done %0b ready %0b ovl %0b want 1 1 0", lk.lock_done, lk.lock_ready, lk.lock_overlap);
    end
    @(posedge clock);
    #1;
    lk.lock_valid = 1'b0;
    n_cmp++; if (lk.lock_ready !== 1'b0) begin n_bad++; $display("FAIL held_second_accept: ready %0b want 0", lk.lock_ready); end
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clock);
      #1;
      if (lk.lock_done === 1'b1) begin lat = i; break; end
    end
    n_cmp++; if (lat != 25 || lk.lock_overlap !== 1'b1) begin n_bad++; $display("FAIL held_second_done: lat %0d ovl %0b want 25 1", lat, lk.lock_overlap); end
  endtask

  initial begin
    reset = 1'b1;
    clear_all = 1'b0;
    rd_x = '0;
    rd_y = '0;
    lk.lock_valid = 1'b0;
    lk.cell_x = '0;
    lk.cell_y = '0;
    test_reset();
    test_single_lock();
    test_one_line();
    test_four_lines();
    test_overlap();
    test_clear_during_shift();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
